// File: rtl/mem_tile_sram_ctrl_pkg.sv
// Shared types and constants for the mem-tile SRAM controller.
// Two requesters: NoC path (via OBI shim) and local DMA/debug path.
package mem_tile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_ctrl_state_e;

    localparam int unsigned NumMemPorts = 2;
    localparam int unsigned PortNoc     = 0;
    localparam int unsigned PortDma     = 1;

endpackage

// File: rtl/mem_tile_sram_ctrl_if.sv
// Word-level requester bus for both controller ports; responses share one rdata.
// Requester drives req/we/addr/wdata/be and holds them until gnt.
interface mem_tile_sram_ctrl_if #(
    parameter int unsigned NumWords  = 2048,
    parameter int unsigned DataWidth = 512
);
    import mem_tile_pkg::*;

    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned BeWidth   = DataWidth / 8;

    logic [NumMemPorts-1:0]                req;
    logic [NumMemPorts-1:0]                gnt;
    logic [NumMemPorts-1:0]                we;
    logic [NumMemPorts-1:0][AddrWidth-1:0] addr;
    logic [NumMemPorts-1:0][DataWidth-1:0] wdata;
    logic [NumMemPorts-1:0][BeWidth-1:0]   be;
    logic [NumMemPorts-1:0]                rvalid;
    logic [DataWidth-1:0]                  rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_tile_sram_ctrl.sv
// Zero-fills the SRAM bank after reset/init_i, then round-robin arbitrates two word ports onto it.
// Grant is same-cycle; every granted access answers on rvalid exactly one cycle later.
module mem_tile_sram_ctrl
    import mem_tile_pkg::*;
#(
    parameter int unsigned NumWords  = 2048,
    parameter int unsigned DataWidth = 512,
    localparam int unsigned AddrWidth = $clog2(NumWords),
    localparam int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 init_i,
    output logic                 init_done_o,
    mem_tile_sram_ctrl_if.slave  bus,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    sram_ctrl_state_e     r_state;
    logic [AddrWidth-1:0] r_init_cnt;
    logic                 r_init_done;
    logic                 r_rr_ptr;
    logic                 r_rsp_vld;
    logic                 r_rsp_port;

    logic w_run;
    logic w_both;
    logic w_winner;
    logic w_any;

    // The init_i cycle itself is dead: no grant and no SRAM access.
    assign w_run    = (r_state == RUN) && !init_i;
    assign w_both   = bus.req[PortNoc] && bus.req[PortDma];
    assign w_winner = w_both ? r_rr_ptr : bus.req[PortDma];
    assign w_any    = w_run && (|bus.req);

    always_comb begin
        bus.gnt = '0;
        if (w_any) begin
            bus.gnt[w_winner] = 1'b1;
        end
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (r_state == INIT) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = r_init_cnt;
            sram_be_o   = '1;
        end else if (w_any) begin
            sram_req_o   = 1'b1;
            sram_we_o    = bus.we[w_winner];
            sram_addr_o  = bus.addr[w_winner];
            sram_wdata_o = bus.wdata[w_winner];
            sram_be_o    = bus.be[w_winner];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + AddrWidth'(1);
                    if (r_init_cnt == LastAddr) begin
                        r_state     <= RUN;
                        r_init_cnt  <= '0;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (init_i) begin
                        r_state     <= INIT;
                        r_init_cnt  <= '0;
                        r_init_done <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= INIT;
                    r_init_cnt  <= '0;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Only a contested grant moves the pointer, so a lone requester never disturbs fairness.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_port <= 1'b0;
        end else begin
            r_rsp_vld  <= w_any;
            r_rsp_port <= w_winner;
            if (w_any && w_both) begin
                r_rr_ptr <= ~w_winner;
            end
        end
    end

    assign init_done_o = r_init_done;
    assign bus.rdata   = sram_rdata_i;

    always_comb begin
        bus.rvalid             = '0;
        bus.rvalid[r_rsp_port] = r_rsp_vld;
    end

    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.gnt));
    a_gnt_has_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((bus.gnt & ~bus.req) == '0));
    a_gnt_when_done : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!init_done_o |-> (bus.gnt == '0)));

endmodule

// File: tb/tb_mem_tile_sram_ctrl.sv
// Directed + randomized bench for mem_tile_sram_ctrl against a cycle-level behavioural model.
module tb_mem_tile_sram_ctrl;

    localparam int NW = 16;
    localparam int DW = 32;
    localparam int AW = $clog2(NW);
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic init;
    logic init_done;
    logic          sram_req, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [BW-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_tile_sram_ctrl_if #(.NumWords(NW), .DataWidth(DW)) bus ();

    mem_tile_sram_ctrl #(.NumWords(NW), .DataWidth(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .init_i       (init),
        .init_done_o  (init_done),
        .bus          (bus),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    // SRAM bank: one port, read data one cycle after the request.
    logic [DW-1:0] sram_mem [NW];
    initial begin
        for (int i = 0; i < NW; i++) sram_mem[i] = $urandom;
        sram_rdata = '0;
    end
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: fill cycles left, round-robin preference, expected memory, one pending response.
    int            m_init_left;
    bit            m_prio;
    logic [DW-1:0] m_mem [NW];
    bit            m_pv, m_pport, m_pwe;
    logic [DW-1:0] m_pdata;
    logic [1:0]    e_gnt, e_rvalid;
    bit            e_done, e_req, e_we, win;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_init_done", init_done, 0);
            m_init_left = NW;
            m_prio      = 1'b0;
            m_pv        = 1'b0;
        end else begin
            e_done = (m_init_left == 0);
            e_gnt = '0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_be = '0; win = 0;
            if (!e_done) begin
                e_req = 1; e_we = 1; e_addr = AW'(NW - m_init_left); e_be = '1;
            end else if (!init && bus.req != 2'b00) begin
                if (bus.req == 2'b11) win = m_prio;
                else                  win = (bus.req == 2'b10);
                e_gnt[win] = 1'b1;
                e_req   = 1;
                e_we    = bus.we[win];
                e_addr  = bus.addr[win];
                e_wdata = bus.wdata[win];
                e_be    = bus.be[win];
            end
            e_rvalid = m_pv ? (2'b01 << m_pport) : 2'b00;

            chk("init_done", init_done, e_done);
            chk("gnt", bus.gnt, e_gnt);
            chk("sram_req", sram_req, e_req);
            if (e_req) begin
                chk("sram_we", sram_we, e_we);
                chk("sram_addr", sram_addr, e_addr);
                if (e_we) begin
                    chk("sram_wdata", sram_wdata, e_wdata);
                    chk("sram_be", sram_be, e_be);
                end
            end
            chk("rvalid", bus.rvalid, e_rvalid);
            if (m_pv && !m_pwe) chk("rdata", bus.rdata, m_pdata);

            m_pv    = (e_gnt != 2'b00);
            m_pport = win;
            m_pwe   = e_we;
            if (e_req) begin
                m_pdata = m_mem[e_addr];
                if (e_we)
                    for (int b = 0; b < BW; b++)
                        if (e_be[b]) m_mem[e_addr][b*8 +: 8] = e_wdata[b*8 +: 8];
            end
            if (!e_done)   m_init_left--;
            else if (init) m_init_left = NW;
            if (e_gnt != 2'b00 && bus.req == 2'b11) m_prio = ~win;
        end
    end

    task automatic op(input int p, input bit w, input int a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_rd, input string nm);
        @(posedge clk); #1;
        bus.req = '0; bus.req[p] = 1'b1; bus.we[p] = w;
        bus.addr[p] = AW'(a); bus.wdata[p] = d; bus.be[p] = '1;
        @(negedge clk);
        chk({nm, "_gnt"}, bus.gnt, 64'(2'b01 << p));
        @(posedge clk); #1;
        bus.req = '0;
        @(negedge clk);
        chk({nm, "_rvalid"}, bus.rvalid, 64'(2'b01 << p));
        if (!w) chk({nm, "_rdata"}, bus.rdata, exp_rd);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!init_done && n < 60) begin
            @(negedge clk); n++;
        end
        chk(nm, init_done, 1);
    endtask

    initial begin
        int n;
        bit got;
        logic [1:0] exp_g, prev_g;
        rst_n = 1'b0; init = 1'b0;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk); n++;
            if (n == 1)  chk("fill_first_addr", sram_addr, 0);
            if (n == 16) chk("fill_last_addr", sram_addr, NW - 1);
            if (init_done) got = 1;
        end
        chk("init_len_cycles", n, NW + 1);

        op(0, 0, 7, '0, 32'h0, "rd7_zero");
        op(0, 1, 3, 32'hA5A5_A5A5, '0, "wr3");
        op(0, 0, 3, '0, 32'hA5A5_A5A5, "rd3");

        // Both ports contend: strict alternation starting at port 0.
        @(posedge clk); #1;
        bus.req = 2'b11; bus.we = 2'b00; bus.addr[0] = AW'(3); bus.addr[1] = AW'(7);
        prev_g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("alt_gnt", bus.gnt, exp_g);
            if (i > 0) chk("alt_rvalid", bus.rvalid, prev_g);
            prev_g = exp_g;
            @(posedge clk); #1;
        end
        bus.req = 2'b00;
        @(negedge clk);
        chk("alt_rvalid_last", bus.rvalid, 2'b10);

        // Port 1 alone: back-to-back grants, pointer untouched.
        @(posedge clk); #1;
        bus.req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("solo1_gnt", bus.gnt, 2'b10);
            @(posedge clk); #1;
        end
        bus.req = 2'b11;
        @(negedge clk);
        chk("rr_after_solo", bus.gnt, 2'b01);
        @(posedge clk); #1;
        bus.req = 2'b00;

        // init_i while both request and a read is in flight.
        @(posedge clk); #1;
        bus.req = 2'b01; bus.we = 2'b00; bus.addr[0] = AW'(3);
        @(negedge clk);
        chk("pre_init_gnt", bus.gnt, 2'b01);
        @(posedge clk); #1;
        bus.req = 2'b11; init = 1'b1;
        @(negedge clk);
        chk("init_cycle_gnt", bus.gnt, 0);
        chk("init_cycle_rvalid", bus.rvalid, 2'b01);
        chk("init_cycle_rdata", bus.rdata, 32'hA5A5_A5A5);
        chk("init_cycle_done", init_done, 1);
        @(posedge clk); #1;
        init = 1'b0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk("init_done_drop", init_done, 0);
            if (bus.gnt != 2'b00) break;
            n++;
            @(posedge clk); #1;
        end
        chk("init_nogrant_cycles", n, NW + 1);
        @(posedge clk); #1;
        bus.req = 2'b00;
        op(0, 0, 3, '0, 32'h0, "rd3_after_init");

        // Reset pulse in the middle of a fill.
        @(posedge clk); #1; init = 1'b1;
        @(posedge clk); #1; init = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (sram_addr != AW'(9) && n < 40);
        chk("midfill_addr9", sram_addr, 9);
        #1 rst_n = 1'b0;
        #1 chk("midrst_done", init_done, 0);
        chk("midrst_rvalid", bus.rvalid, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("refill_addr0", sram_addr, 0);
        chk("refill_we", sram_we, 1);
        wait_done("refill_done");

        // Randomized traffic with rare re-initialisation.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.req = 2'($urandom_range(0, 3));
            bus.we  = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                bus.addr[p]  = AW'($urandom_range(0, NW - 1));
                bus.wdata[p] = $urandom;
                bus.be[p]    = BW'($urandom_range(0, (1 << BW) - 1));
            end
            init = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk); #1;
        bus.req = 2'b00; init = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
